// File: rtl/apb_mem_slave.sv
// APB completer with a small byte-wide register file, programmable wait states,
// an external stall input and pslverr on out-of-range addresses.
module apb_mem_slave #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              s_wait,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   prdata_q;
  logic                pready_q;
  logic                pslverr_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          // Only a genuine setup phase starts a transfer; a stray penable is ignored.
          if (psel && !penable) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            cnt_q   <= CNT_W'(WAIT_CYCLES);
            state_q <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!psel) begin
            pslverr_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (s_wait) begin
            state_q <= ST_WAIT;
          end else begin
            pready_q <= 1'b1;
            state_q  <= ST_RESP;
            if (!addr_valid(addr_q)) begin
              prdata_q  <= '0;
              pslverr_q <= 1'b1;
            end else if (write_q) begin
              mem_q[addr_q] <= wdata_q;
              pslverr_q     <= 1'b0;
            end else begin
              prdata_q  <= mem_q[addr_q];
              pslverr_q <= 1'b0;
            end
          end
        end

        ST_RESP: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= ST_IDLE;
        end

        default: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: one instance with no extra wait states
// and one with three, driven by an APB master task and checked by a monitor.
module tb_apb_mem_slave;

  localparam int DEPTH = 12;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst     [2];
  logic       psel    [2];
  logic       penable [2];
  logic       pwrite  [2];
  logic [3:0] paddr   [2];
  logic [7:0] pwdata  [2];
  logic       s_wait  [2];
  logic [7:0] prdata  [2];
  logic       pready  [2];
  logic       pslverr [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] ref_mem [2][16];
  logic [7:0] last_pr [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_mem_slave #(.ADDR_W(4), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .s_wait(s_wait[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb_mem_slave #(.ADDR_W(4), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .s_wait(s_wait[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1])
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Monitor: every pready must match the oldest outstanding expectation.
  task automatic mon(input int d);
    exp_t e;
    bit   got = 1'b0;
    if (d == 0) begin
      if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
    end else begin
      if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL unexpected_pready dut%0d: pready=1 with no transfer outstanding at cycle %0d", d, cyc);
    end else begin
      check($sformatf("prdata dut%0d", d), int'(prdata[d]), int'(e.data));
      check($sformatf("pslverr dut%0d", d), int'(pslverr[d]), int'(e.err));
      check($sformatf("pready_cycle dut%0d", d), cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d] === 1'b0 && pready[d] === 1'b1) mon(d);
    end
  end

  // Reference model: plain array semantics of the register file.
  task automatic model(input int d, input bit wr, input logic [3:0] a,
                       input logic [7:0] wd, output exp_t e);
    if (int'(a) >= DEPTH) begin
      e.data = 8'h00; e.err = 1'b1; last_pr[d] = 8'h00;
    end else if (wr) begin
      ref_mem[d][a] = wd; e.data = last_pr[d]; e.err = 1'b0;
    end else begin
      e.data = ref_mem[d][a]; last_pr[d] = e.data; e.err = 1'b0;
    end
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < 16; i++) ref_mem[d][i] = 8'h00;
    last_pr[d] = 8'h00;
  endtask

  // Must be called #1 after a rising edge; returns #1 after a rising edge.
  task automatic xfer(input int d, input bit wr, input logic [3:0] a,
                      input logic [7:0] wd, input int stall);
    exp_t e;
    int   n    = (d == 0) ? 0 : 3;
    bit   seen = 1'b0;
    model(d, wr, a, wd, e);
    e.cyc = cyc + 2 + n + stall;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = a; pwdata[d] = wd; s_wait[d] = (stall > 0);
    @(posedge clk); #1 penable[d] = 1'b1;
    if (stall > 0) begin
      repeat (n + stall) @(posedge clk);
      #1 s_wait[d] = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pready[d] === 1'b1) begin seen = 1'b1; break; end
    end
    check($sformatf("pready_seen dut%0d", d), int'(seen), 1);
    @(posedge clk); #1 psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  // Write that is abandoned by dropping psel while stalled.
  task automatic abort_xfer(input int d, input logic [3:0] a, input logic [7:0] wd);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
    paddr[d] = a; pwdata[d] = wd; s_wait[d] = 1'b1;
    @(posedge clk); #1 penable[d] = 1'b1;
    repeat (2) @(posedge clk);
    #1 psel[d] = 1'b0; penable[d] = 1'b0;
    @(posedge clk); #1 s_wait[d] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t       dummy;
    bit         wr;
    logic [3:0] a;
    logic [7:0] wd;
    int         d;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
      paddr[k] = '0; pwdata[k] = '0; s_wait[k] = 1'b0;
      model_reset(k);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_prdata dut%0d", k), int'(prdata[k]), 0);
      check($sformatf("reset_pready dut%0d", k), int'(pready[k]), 0);
      check($sformatf("reset_pslverr dut%0d", k), int'(pslverr[k]), 0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;

    // Fresh memory reads as zero, three cycles per transfer.
    for (int i = 0; i < DEPTH; i++) xfer(0, 1'b0, 4'(i), 8'h00, 0);

    // Stalled write then readback.
    xfer(0, 1'b1, 4'd3, 8'hA5, 2);
    xfer(0, 1'b0, 4'd3, 8'h00, 0);

    // Three fixed wait states.
    xfer(1, 1'b1, 4'd11, 8'h7E, 0);
    xfer(1, 1'b0, 4'd11, 8'h00, 0);

    // Out-of-range write and read, then full readback.
    xfer(0, 1'b1, 4'd13, 8'hC8, 0);
    xfer(0, 1'b0, 4'd13, 8'h00, 0);
    for (int i = 0; i < DEPTH; i++) xfer(0, 1'b0, 4'(i), 8'h00, 0);

    // Aborted write leaves the location untouched.
    xfer(0, 1'b1, 4'd5, 8'h3C, 0);
    abort_xfer(0, 4'd5, 8'h55);
    xfer(0, 1'b0, 4'd5, 8'h00, 0);
    abort_xfer(1, 4'd11, 8'h55);
    xfer(1, 1'b0, 4'd11, 8'h00, 0);

    // penable without setup produces no response.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 4'd3;
    repeat (3) @(posedge clk);
    #1 psel[0] = 1'b0; penable[0] = 1'b0;
    xfer(0, 1'b0, 4'd3, 8'h00, 0);

    // Reset in the middle of a stalled write.
    xfer(0, 1'b1, 4'd2, 8'h99, 0);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 4'd2; pwdata[0] = 8'h11; s_wait[0] = 1'b1;
    @(posedge clk); #1 penable[0] = 1'b1;
    @(posedge clk); #1 rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_pready", int'(pready[0]), 0);
    check("midreset_pslverr", int'(pslverr[0]), 0);
    check("midreset_prdata", int'(prdata[0]), 0);
    rst[0] = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0; s_wait[0] = 1'b0;
    model_reset(0);
    @(posedge clk); #1;
    xfer(0, 1'b0, 4'd2, 8'h00, 0);
    xfer(0, 1'b0, 4'd3, 8'h00, 0);

    // Randomized traffic on both instances.
    for (int i = 0; i < 120; i++) begin
      d  = int'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      wr = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      if ($urandom_range(0, 9) == 0) abort_xfer(d, a, wd);
      else xfer(d, wr, a, wd, int'($urandom_range(0, 3)));
    end
    for (int k = 0; k < DEPTH; k++) begin
      xfer(0, 1'b0, 4'(k), 8'h00, 0);
      xfer(1, 1'b0, 4'(k), 8'h00, 0);
    end

    repeat (4) @(posedge clk);
    check("outstanding dut0", q0.size(), 0);
    check("outstanding dut1", q1.size(), 0);
    dummy.cyc = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

APB completer that sits directly downstream of the APB master (`apb_w_top` bus side) and services its setup/access transfers. Holds a small byte-wide register file, inserts a programmable number of wait states plus an externally driven stall (`s_wait`), and flags out-of-range addresses with `pslverr`. Replaces the behavioural slave model so that master wait-state handling can be exercised deterministically.

## Interface
- `ADDR_W`, 4: address width; `paddr` is `ADDR_W` bits.
- `DATA_W`, 8: data width of `pwdata`, `prdata` and the storage.
- `DEPTH`, 12: number of implemented locations. Valid addresses are 0..DEPTH-1, with DEPTH ≤ 2^ADDR_W.
- `WAIT_CYCLES`, 0: fixed extra wait states inserted on every transfer (0..15).

- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `psel` input 1: APB select.
- `penable` input 1: APB enable, high in the access phase.
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input ADDR_W: transfer address.
- `pwdata` input DATA_W: write data.
- `s_wait` input 1: external stall request; while high the slave withholds `pready`.
- `prdata` output DATA_W: read data, registered.
- `pready` output 1: transfer-complete strobe, registered.
- `pslverr` output 1: error response, valid only while `pready`=1, registered.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - `pready`=0, `pslverr`=0.
  - On a rising edge with `psel`=1 and `penable`=0 (setup phase), latch `paddr`, `pwrite` and `pwdata`, load `cnt` with `WAIT_CYCLES`, then go to WAIT.
  - Any other bus state stays in IDLE.
- **WAIT** (evaluated each edge, first match wins):
  - `psel`=0: abort. Go to IDLE with no memory write, `prdata` unchanged, `pslverr`=0.
  - `cnt`≠0: decrement `cnt` and stay in WAIT.
  - `s_wait`=1: stay in WAIT; `cnt` remains 0.
  - Otherwise: complete the transfer, set `pready`=1, go to RESP.
- **Completion**
  - Write to a valid address: `mem[addr]` ← latched `pwdata`; `pslverr`=0; `prdata` unchanged.
  - Read from a valid address: `prdata` ← `mem[addr]`; `pslverr`=0.
  - Address ≥ DEPTH: no memory write, `prdata` ← 0 (also on writes), `pslverr`=1.
- **RESP**
  - `pready` and `pslverr` are held for exactly one cycle.
  - At the next edge, return unconditionally to IDLE with `pready`=0 and `pslverr`=0. `prdata` holds its value until the next read or error completion.
- `s_wait` is ignored in IDLE and RESP. It is sampled in WAIT only after `cnt` reaches 0.
- Back-to-back transfers: the master's next setup phase coincides with the cycle after RESP. IDLE samples it on the following edge, so the slave never misses a setup.

## Timing
- **Reset**
  - All locations of `mem` are cleared to 0.
  - `prdata`=0, `pready`=0, `pslverr`=0, `cnt`=0, state = IDLE.
  - `rst` asserted in any state takes effect at that edge, mid-transfer included. A write in flight is discarded.
- **Latency**
  - Setup sampled at edge E0. With `WAIT_CYCLES`=N and `s_wait` low, `pready` rises after edge E0+1+N.
  - The minimum transfer is therefore setup + 2 access cycles, i.e. 3 bus cycles, because the registered `pready` inserts one inherent wait state.
  - Every cycle in which `s_wait`=1 is sampled in WAIT with `cnt`=0 adds one cycle.
- **Pulse width**: `pready` is high for exactly 1 cycle per completed transfer. It is never asserted for an aborted transfer.
- **Data timing**: `prdata` and `pslverr` are valid in the same cycle `pready` is high.
- **Write visibility**: a write is visible to a read whose setup phase follows it.
- **Protocol violation**: `penable`=1 sampled in IDLE without a preceding setup is ignored and produces no response.

## Test plan
- Reset, then with `WAIT_CYCLES`=0 read addresses 0..11 → `prdata`=0x00 and `pslverr`=0 for each; `pready` pulses 1 cycle each, 3 cycles per transfer.
- Write 0xA5 to address 3 with `s_wait` high for 2 cycles, then read address 3 → the write's `pready` is delayed 2 cycles versus the no-stall case; the read returns 0xA5.
- With `WAIT_CYCLES`=3, write 0x7E to address 11, then read it back → `pready` appears 4 edges after the setup edge; read data = 0x7E.
- Write 0xC8 to address 13, then read address 13 (DEPTH=12) → `pslverr`=1 with `pready` on both transfers; `prdata`=0x00; no location changes (a full readback of 0..11 is unchanged).
- Drop `psel` during WAIT (`s_wait` held high) on a write of 0x55 to address 5 → no `pready`, FSM back in IDLE; reading address 5 returns its previous value.
- Write 0x99 to address 2, then assert `rst` for 1 cycle during the wait phase of a following write of 0x11 to address 2 → `pready`, `pslverr` and `prdata` are 0 after the reset edge; reading address 2 returns 0x00.
